// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: frames bits with start/bit_en and presents N-bit words on a valid/ready port.
// Optional macro SIPO_PARITY_EN adds a trailing even-parity bit per frame and the parity_err output.
module sipo_deserializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         bit_en,
  input  logic         start,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun
`ifdef SIPO_PARITY_EN
  , output logic       parity_err
`endif
);

  localparam int CW = $clog2(N + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [N-1:0]   sr, sr_next;
  logic [N-1:0]   word;
  logic           word_done;
`ifdef SIPO_PARITY_EN
  logic           par_bad;
`endif

  // Shifting into an empty register gives the first-bit placement for a new frame.
  function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[N-2:0], b};
    else           return {b, cur[N-1:1]};
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sr_next    = sr;
    word       = sr;
    word_done  = 1'b0;
`ifdef SIPO_PARITY_EN
    par_bad    = 1'b0;
`endif
    if (bit_en) begin
      if (start) begin
        state_next = SHIFT;
        cnt_next   = CW'(1);
        sr_next    = shift_in('0, serial_in);
      end else begin
        unique case (state)
          SHIFT: begin
            sr_next = shift_in(sr, serial_in);
            if (cnt == CW'(N - 1)) begin
`ifdef SIPO_PARITY_EN
              state_next = PARITY;
              cnt_next   = CW'(N);
`else
              state_next = IDLE;
              cnt_next   = '0;
              word_done  = 1'b1;
              word       = shift_in(sr, serial_in);
`endif
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
`ifdef SIPO_PARITY_EN
          PARITY: begin
            state_next = IDLE;
            cnt_next   = '0;
            word_done  = 1'b1;
            word       = sr;
            par_bad    = ^{sr, serial_in};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sr    <= sr_next;
      busy  <= (state_next != IDLE);
      // A completing word wins over a consume on the same edge, so out_valid stays set.
      if (word_done) begin
        data_out  <= word;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
`ifdef SIPO_PARITY_EN
        parity_err <= par_bad;
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
